// File: rtl/sdram_bist_pkg.sv
// sdram_bist_pkg: shared types and constants for the SDRAM built-in self-test.
//   state_t      - top-level sequencer states
//   MODE_*       - pattern select encodings
//   LFSR_*       - Galois LFSR taps and seed for the pseudo-random pattern
//   CHECK_*      - checkerboard words for even/odd word addresses
//   lfsr_next()  - one right-shift step of the Galois LFSR
package sdram_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0]  MODE_ADDR  = 2'd0;
  localparam logic [1:0]  MODE_NADDR = 2'd1;
  localparam logic [1:0]  MODE_LFSR  = 2'd2;
  localparam logic [1:0]  MODE_CHECK = 2'd3;

  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam logic [15:0] CHECK_EVEN = 16'h5555;
  localparam logic [15:0] CHECK_ODD  = 16'hAAAA;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/sdram_bist_patgen.sv
// sdram_bist_patgen: test-pattern generator, one word per advance.
//   clk, reset : clock and synchronous active-high reset
//   load       : restart the sequence for the given mode (word 0)
//   advance    : step to the next word
//   mode       : pattern select (address, ~address, LFSR, checkerboard)
//   idx_lsb    : LSB of the current word index (checkerboard phase)
//   data       : pattern word for the current index
// A single 16-bit register serves as word counter for the address modes
// and as LFSR state for the pseudo-random mode.
module sdram_bist_patgen
  import sdram_bist_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        advance,
  input  logic [1:0]  mode,
  input  logic        idx_lsb,
  output logic [15:0] data
);

  logic [15:0] gen;

  // Generator state: seed on load, step on advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      gen <= 16'h0000;
    end else if (load) begin
      gen <= (mode == MODE_LFSR) ? LFSR_SEED : 16'h0000;
    end else if (advance) begin
      gen <= (mode == MODE_LFSR) ? lfsr_next(gen) : gen + 16'd1;
    end else begin
      gen <= gen;
    end
  end

  // Pattern word for the current index.
  always_comb begin
    data = 16'h0000;
    case (mode)
      MODE_ADDR:  data = gen;
      MODE_NADDR: data = ~gen;
      MODE_LFSR:  data = gen;
      MODE_CHECK: data = idx_lsb ? CHECK_ODD : CHECK_EVEN;
      default:    data = gen;
    endcase
  end

endmodule

// File: rtl/sdram_bist.sv
// sdram_bist: Avalon-MM master that writes a pattern over WORDS 16-bit words,
// reads it back with up to MAX_PENDING pipelined reads and reports the result.
//   clk, reset        : clock, synchronous active-high reset
//   start, mode       : run request (IDLE/DONE only) and pattern select
//   busy, done, pass  : status; pass valid while done
//   err_count         : saturating mismatch count
//   first_err_addr    : word address of the first mismatch
//   avm_*             : Avalon-MM master port toward the SDRAM controller
module sdram_bist
  import sdram_bist_pkg::*;
#(
  parameter int WORDS       = 33554432,
  parameter int ADDR_W      = 26,
  parameter int MAX_PENDING = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [24:0]       first_err_addr,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [15:0]       avm_writedata,
  output logic [1:0]        avm_byteenable,
  input  logic              avm_waitrequest,
  input  logic [15:0]       avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam int              OUT_W    = $clog2(MAX_PENDING + 1);
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_PENDING);
  localparam logic [24:0]     LAST_PTR = 25'(WORDS - 1);

  state_t             state, state_nx;
  logic [24:0]        ptr;
  logic [24:0]        rsp_ptr;
  logic [OUT_W-1:0]   outstanding;
  logic [1:0]         mode_r;
  logic               mismatch_r;
  logic [24:0]        mis_addr_r;
  logic               start_acc, wr_acc, rd_acc, rsp_take;
  logic [1:0]         gen_mode;
  logic [15:0]        exp_data;

  assign start_acc = start && (state == ST_IDLE || state == ST_DONE);
  assign wr_acc    = avm_write && !avm_waitrequest;
  assign rd_acc    = avm_read && !avm_waitrequest;
  // Responses outside READ/DRAIN (e.g. left over from an aborted run) are dropped.
  assign rsp_take  = avm_readdatavalid && (state == ST_READ || state == ST_DRAIN);
  // Generators must see the new mode on the very edge that loads them.
  assign gen_mode  = start_acc ? mode : mode_r;

  sdram_bist_patgen u_wr_gen (
    .clk(clk), .reset(reset), .load(start_acc), .advance(wr_acc),
    .mode(gen_mode), .idx_lsb(ptr[0]), .data(avm_writedata)
  );

  sdram_bist_patgen u_rd_gen (
    .clk(clk), .reset(reset), .load(start_acc), .advance(rsp_take),
    .mode(gen_mode), .idx_lsb(rsp_ptr[0]), .data(exp_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (start) state_nx = ST_WRITE; else state_nx = ST_IDLE;
      ST_WRITE: if (wr_acc && ptr == LAST_PTR) state_nx = ST_READ; else state_nx = ST_WRITE;
      ST_READ:  if (rd_acc && ptr == LAST_PTR) state_nx = ST_DRAIN; else state_nx = ST_READ;
      ST_DRAIN: begin
        if (avm_readdatavalid && outstanding == OUT_W'(1)) state_nx = ST_DONE;
        else state_nx = ST_DRAIN;
      end
      ST_DONE:  if (start) state_nx = ST_WRITE; else state_nx = ST_DONE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Status and bus-control outputs decoded from state.
  always_comb begin
    busy      = (state == ST_WRITE) || (state == ST_READ) || (state == ST_DRAIN);
    done      = (state == ST_DONE);
    avm_write = (state == ST_WRITE);
    avm_read  = (state == ST_READ) && (outstanding < MAX_OUT);
    // The final compare is still in mismatch_r during the first DONE cycle.
    pass      = done && (err_count == 16'h0000) && !mismatch_r;
  end

  assign avm_address    = ADDR_W'({ptr, 1'b0});
  assign avm_byteenable = 2'b11;

  // Pointers, outstanding-read counter and the two-stage compare/count pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr            <= 25'd0;
      rsp_ptr        <= 25'd0;
      outstanding    <= '0;
      mode_r         <= 2'd0;
      mismatch_r     <= 1'b0;
      mis_addr_r     <= 25'd0;
      err_count      <= 16'h0000;
      first_err_addr <= 25'd0;
    end else if (start_acc) begin
      ptr            <= 25'd0;
      rsp_ptr        <= 25'd0;
      outstanding    <= '0;
      mode_r         <= mode;
      mismatch_r     <= 1'b0;
      mis_addr_r     <= 25'd0;
      err_count      <= 16'h0000;
      first_err_addr <= 25'd0;
    end else begin
      if (wr_acc)      ptr <= (ptr == LAST_PTR) ? 25'd0 : ptr + 25'd1;
      else if (rd_acc) ptr <= ptr + 25'd1;
      else             ptr <= ptr;

      if (rd_acc && !rsp_take)      outstanding <= outstanding + OUT_W'(1);
      else if (!rd_acc && rsp_take) outstanding <= outstanding - OUT_W'(1);
      else                          outstanding <= outstanding;

      if (rsp_take) begin
        rsp_ptr    <= rsp_ptr + 25'd1;
        mismatch_r <= (avm_readdata != exp_data);
        mis_addr_r <= rsp_ptr;
      end else begin
        mismatch_r <= 1'b0;
      end

      if (mismatch_r) begin
        if (err_count == 16'h0000) first_err_addr <= mis_addr_r;
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_sdram_bist.sv
// Directed bench for sdram_bist with WORDS=16: behavioural SDRAM with
// configurable read latency, optional random waitrequest and a bit-3 fault on word 5.
module tb_sdram_bist;

  localparam int WORDS = 16;
  localparam int ADDR_W = 26;
  localparam int MAX_PENDING = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic [1:0]        mode = 2'd0;
  logic              busy, done, pass;
  logic [15:0]       err_count;
  logic [24:0]       first_err_addr;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read, avm_write;
  logic [15:0]       avm_writedata;
  logic [1:0]        avm_byteenable;
  logic              avm_waitrequest = 1'b0;
  logic [15:0]       avm_readdata;
  logic              avm_readdatavalid;

  sdram_bist #(.WORDS(WORDS), .ADDR_W(ADDR_W), .MAX_PENDING(MAX_PENDING)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_addr(first_err_addr), .avm_address(avm_address),
    .avm_read(avm_read), .avm_write(avm_write), .avm_writedata(avm_writedata),
    .avm_byteenable(avm_byteenable), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory model controls, written only by the test sequence.
  int lat = 2;
  bit wait_en = 1'b0;
  bit fault_en = 1'b0;
  bit stat_clr = 1'b0;

  logic [15:0] mem [16] = '{default: 16'h0000};
  logic        pipe_v [16] = '{default: 1'b0};
  logic [3:0]  pipe_a [16] = '{default: 4'd0};
  logic [ADDR_W-1:0] wlog_a [256];
  logic [15:0] wlog_d [256];
  int wr_n = 0;
  int out_cnt = 0;
  int out_max = 0;
  int rd_full_viol = 0;
  int stab_err = 0;
  logic prev_hold = 1'b0;
  logic [ADDR_W-1:0] prev_a = '0;
  logic prev_r = 1'b0, prev_w = 1'b0;
  logic [15:0] prev_d = 16'h0000;

  logic wr_acc_t, rd_acc_t, rdv_dec;
  assign wr_acc_t = avm_write && !avm_waitrequest;
  assign rd_acc_t = avm_read && !avm_waitrequest;
  assign avm_readdatavalid = pipe_v[lat-1];
  assign avm_readdata = mem[pipe_a[lat-1]] ^
                        ((fault_en && pipe_a[lat-1] == 4'd5) ? 16'h0008 : 16'h0000);
  assign rdv_dec = avm_readdatavalid && (out_cnt > 0);

  // Memory, read pipeline, waitrequest generation and bus monitors.
  always @(posedge clk) begin
    if (wr_acc_t) begin
      mem[avm_address[4:1]] <= avm_writedata;
      wlog_a[wr_n & 255] <= avm_address;
      wlog_d[wr_n & 255] <= avm_writedata;
      wr_n <= wr_n + 1;
    end
    for (int i = 15; i > 0; i--) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_a[i] <= pipe_a[i-1];
    end
    pipe_v[0] <= rd_acc_t;
    pipe_a[0] <= avm_address[4:1];
    avm_waitrequest <= wait_en ? 1'($urandom_range(0, 1)) : 1'b0;

    if (reset) out_cnt <= 0;
    else       out_cnt <= out_cnt + (rd_acc_t ? 1 : 0) - (rdv_dec ? 1 : 0);

    prev_hold <= (avm_read || avm_write) && avm_waitrequest;
    prev_a <= avm_address; prev_r <= avm_read; prev_w <= avm_write; prev_d <= avm_writedata;

    if (stat_clr) begin
      out_max <= 0; rd_full_viol <= 0; stab_err <= 0;
    end else begin
      if (out_cnt > out_max) out_max <= out_cnt;
      if (avm_read && out_cnt >= MAX_PENDING) rd_full_viol <= rd_full_viol + 1;
      if (prev_hold && (avm_address != prev_a || avm_read != prev_r ||
                        avm_write != prev_w || (prev_w && avm_writedata != prev_d)))
        stab_err <= stab_err + 1;
    end
  end

  int run_cycles;
  bit timed_out;
  int wr_base;

  // Start one test and count edges after the start-sampling edge until done.
  task automatic run_bist(input logic [1:0] m, input int l, input bit w, input bit f,
                          input bit hold);
    lat = l; wait_en = w; fault_en = f;
    @(negedge clk);
    mode = m; start = 1'b1; stat_clr = 1'b1; wr_base = wr_n;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    if (!hold) start = 1'b0;
    run_cycles = 0; timed_out = 1'b0;
    while (1) begin
      @(posedge clk);
      run_cycles++;
      #1;
      if (done) break;
      if (run_cycles >= 3000) begin timed_out = 1'b1; break; end
    end
    start = 1'b0;
    wait_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL reset_pass got %b want 0", pass); end
    checks++; if (err_count !== 16'h0000) begin errors++; $display("FAIL reset_err got %h want 0", err_count); end
    checks++; if (first_err_addr !== 25'd0) begin errors++; $display("FAIL reset_fea got %h want 0", first_err_addr); end
    checks++; if (avm_read !== 1'b0 || avm_write !== 1'b0) begin errors++; $display("FAIL reset_rw got %b%b want 00", avm_read, avm_write); end
    checks++; if (avm_address !== '0) begin errors++; $display("FAIL reset_addr got %h want 0", avm_address); end
    checks++; if (avm_writedata !== 16'h0000) begin errors++; $display("FAIL reset_wdata got %h want 0", avm_writedata); end
    checks++; if (avm_byteenable !== 2'b11) begin errors++; $display("FAIL reset_be got %b want 11", avm_byteenable); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Mode 0, zero wait, latency 2: done visible after 2*16+2 edges, i.e. in cycle 35.
  task automatic test_mode0();
    run_bist(2'd0, 2, 1'b0, 1'b0, 1'b0);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL m0_timeout got %b want 0", timed_out); end
    checks++; if (run_cycles !== 34) begin errors++; $display("FAIL m0_cycles got %0d want 34", run_cycles); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL m0_pass got %b want 1", pass); end
    checks++; if (err_count !== 16'h0000) begin errors++; $display("FAIL m0_err got %h want 0", err_count); end
    checks++; if (wr_n - wr_base !== 16) begin errors++; $display("FAIL m0_nwrites got %0d want 16", wr_n - wr_base); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (wlog_a[(wr_base + i) & 255] !== ADDR_W'(2 * i) || wlog_d[(wr_base + i) & 255] !== 16'(i)) begin
        errors++;
        $display("FAIL m0_write%0d got %h/%h want %h/%h", i, wlog_a[(wr_base + i) & 255],
                 wlog_d[(wr_base + i) & 255], 2 * i, i);
      end
    end
  endtask

  task automatic test_waitstates();
    run_bist(2'd3, 3, 1'b1, 1'b0, 1'b0);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL ws_timeout got %b want 0", timed_out); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL ws_pass got %b want 1", pass); end
    checks++; if (stab_err !== 0) begin errors++; $display("FAIL ws_stability got %0d want 0", stab_err); end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (mem[i] !== ((i % 2 == 1) ? 16'hAAAA : 16'h5555)) begin
        errors++; $display("FAIL ws_mem%0d got %h want %h", i, mem[i], (i % 2 == 1) ? 16'hAAAA : 16'h5555);
      end
    end
  endtask

  task automatic test_fault();
    run_bist(2'd1, 2, 1'b0, 1'b1, 1'b0);
    fault_en = 1'b0;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL flt_done got %b want 1", done); end
    checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL flt_err got %h want 1", err_count); end
    checks++; if (first_err_addr !== 25'd5) begin errors++; $display("FAIL flt_fea got %0d want 5", first_err_addr); end
    checks++; if (pass !== 1'b0) begin errors++; $display("FAIL flt_pass got %b want 0", pass); end
  endtask

  task automatic test_latency10();
    run_bist(2'd0, 10, 1'b0, 1'b0, 1'b0);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL l10_timeout got %b want 0", timed_out); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL l10_pass got %b want 1", pass); end
    checks++; if (out_max !== 8) begin errors++; $display("FAIL l10_maxout got %0d want 8", out_max); end
    checks++; if (rd_full_viol !== 0) begin errors++; $display("FAIL l10_read_when_full got %0d want 0", rd_full_viol); end
  endtask

  // Start held high for the whole run must neither restart nor extend it.
  task automatic test_lfsr();
    run_bist(2'd2, 2, 1'b0, 1'b0, 1'b1);
    checks++; if (wlog_d[wr_base & 255] !== 16'hACE1) begin errors++; $display("FAIL lfsr_w0 got %h want ace1", wlog_d[wr_base & 255]); end
    checks++; if (wlog_d[(wr_base + 1) & 255] !== 16'hE270) begin errors++; $display("FAIL lfsr_w1 got %h want e270", wlog_d[(wr_base + 1) & 255]); end
    checks++; if (wr_n - wr_base !== 16) begin errors++; $display("FAIL lfsr_nwrites got %0d want 16", wr_n - wr_base); end
    checks++; if (run_cycles !== 34) begin errors++; $display("FAIL lfsr_cycles got %0d want 34", run_cycles); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL lfsr_pass got %b want 1", pass); end
  endtask

  task automatic test_reset_midread();
    int n;
    lat = 4;
    @(negedge clk);
    mode = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(out_cnt == 4 && avm_read) && n < 200) begin @(negedge clk); n++; end
    checks++; if (out_cnt !== 4) begin errors++; $display("FAIL rst_inflight got %0d want 4", out_cnt); end
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin errors++; $display("FAIL rst_status got %b%b%b want 000", busy, done, pass); end
    checks++; if (avm_read !== 1'b0 || avm_write !== 1'b0 || avm_address !== '0) begin errors++; $display("FAIL rst_bus got %b%b %h want 00 0", avm_read, avm_write, avm_address); end
    checks++; if (err_count !== 16'h0000) begin errors++; $display("FAIL rst_err got %h want 0", err_count); end
    @(negedge clk);
    reset = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_stale_state got %b%b want 00", busy, done); end
    checks++; if (err_count !== 16'h0000) begin errors++; $display("FAIL rst_stale_err got %h want 0", err_count); end
    run_bist(2'd0, 4, 1'b0, 1'b0, 1'b0);
    checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL rst_rerun_timeout got %b want 0", timed_out); end
    checks++; if (pass !== 1'b1) begin errors++; $display("FAIL rst_rerun_pass got %b want 1", pass); end
    checks++; if (err_count !== 16'h0000) begin errors++; $display("FAIL rst_rerun_err got %h want 0", err_count); end
  endtask

  initial begin
    test_reset();
    test_mode0();
    test_waitstates();
    test_fault();
    test_latency10();
    test_lfsr();
    test_reset_midread();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
